// File: rtl/axil_master.sv
// ---------------------------------------------------------------------------
// axil_master
//   Single-outstanding AXI4-Lite master. A command taken on the cmd_* port is
//   turned into one AXI-Lite write (AW + W, then B) or read (AR, then R), and
//   the result is returned on the rsp_* port.
//
//   Optional build macro: AXIL_MASTER_TIMEOUT_EN
//     When defined, a cycle counter bounds the time spent waiting on the bus;
//     after TIMEOUT_CYCLES the transaction is abandoned and answered with
//     SLVERR (2'b10) and rsp_timeout=1. When undefined there is no counter,
//     the master waits indefinitely and rsp_timeout is tied low.
//
//   Ports
//     ACLK, ARESET              clock (rising edge) and synchronous active-high reset
//     cmd_valid / cmd_ready     command handshake
//     cmd_write                 1 = write, 0 = read
//     cmd_addr, cmd_wdata, cmd_wstrb   address, write data, byte strobes
//     rsp_valid / rsp_ready     response handshake
//     rsp_write, rsp_rdata, rsp_resp, rsp_timeout   op type, read data, AXI resp, timeout flag
//     AW_*, W_*, B_*, AR_*, R_* AXI-Lite master channels
//     dbg_state                 current FSM state (encoding: localparams below)
//
//   Handshake rule (all channels, both sides): a transfer happens on a rising
//   edge where VALID and READY are both high. A VALID, once raised, stays high
//   with its payload unchanged until that transfer (the only exception being a
//   timeout abandon). Every VALID/READY driven here is a flop output, so no
//   input reaches them combinationally.
// ---------------------------------------------------------------------------
module axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // AXI-Lite write address
  output logic                    AW_VALID,
  input  logic                    AW_READY,
  output logic [ADDR_WIDTH-1:0]   AW_ADDR,
  // AXI-Lite write data
  output logic                    W_VALID,
  input  logic                    W_READY,
  output logic [DATA_WIDTH-1:0]   W_DATA,
  output logic [DATA_WIDTH/8-1:0] W_STRB,
  // AXI-Lite write response
  input  logic                    B_VALID,
  output logic                    B_READY,
  input  logic [1:0]              B_RESP,
  // AXI-Lite read address
  output logic                    AR_VALID,
  input  logic                    AR_READY,
  output logic [ADDR_WIDTH-1:0]   AR_ADDR,
  // AXI-Lite read data
  input  logic                    R_VALID,
  output logic                    R_READY,
  input  logic [DATA_WIDTH-1:0]   R_DATA,
  input  logic [1:0]              R_RESP,
  // debug
  output logic [2:0]              dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0] state;

  assign dbg_state = state;

  // In WR_REQ a channel whose VALID is already low has finished its transfer,
  // so "both done" is: each channel is either already done or transferring now.
  logic wr_addr_done;
  logic wr_data_done;

  assign wr_addr_done = !AW_VALID || AW_READY;
  assign wr_data_done = !W_VALID  || W_READY;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCNT_W-1:0] tcnt;
  logic              cmd_write_q;
  logic              in_bus;
  logic              bus_finishing;
  logic              tmo_hit;

  assign in_bus        = (state == WR_REQ) || (state == WR_RESP) ||
                         (state == RD_REQ) || (state == RD_RESP);
  // A response arriving on the very cycle the limit is reached wins.
  assign bus_finishing = ((state == WR_RESP) && B_VALID) ||
                         ((state == RD_RESP) && R_VALID);
  assign tmo_hit       = (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      AW_VALID  <= 1'b0;
      W_VALID   <= 1'b0;
      AR_VALID  <= 1'b0;
      B_READY   <= 1'b0;
      R_READY   <= 1'b0;
      AW_ADDR   <= '0;
      AR_ADDR   <= '0;
      W_DATA    <= '0;
      W_STRB    <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      tcnt        <= '0;
      cmd_write_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready comes up one cycle after reset release and stays up
          // until a command is taken.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            AW_ADDR   <= cmd_addr;
            AR_ADDR   <= cmd_addr;
            W_DATA    <= cmd_wdata;
            W_STRB    <= cmd_wstrb;
`ifdef AXIL_MASTER_TIMEOUT_EN
            cmd_write_q <= cmd_write;
`endif
            if (cmd_write) begin
              AW_VALID <= 1'b1;
              W_VALID  <= 1'b1;
              state    <= WR_REQ;
            end else begin
              AR_VALID <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W retire independently, in either order or together.
          if (AW_READY) AW_VALID <= 1'b0;
          if (W_READY)  W_VALID  <= 1'b0;
          if (wr_addr_done && wr_data_done) begin
            B_READY <= 1'b1;
            state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (B_VALID) begin
            B_READY   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= B_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state     <= RSP;
          end
        end

        RD_REQ: begin
          if (AR_READY) begin
            AR_VALID <= 1'b0;
            R_READY  <= 1'b1;
            state    <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (R_VALID) begin
            R_READY   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_write <= 1'b0;
            rsp_rdata <= R_DATA;
            rsp_resp  <= R_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            state     <= RSP;
          end
        end

        RSP: begin
          // rsp_* fields are left untouched here, so they hold until taken.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
          AW_VALID  <= 1'b0;
          W_VALID   <= 1'b0;
          AR_VALID  <= 1'b0;
          B_READY   <= 1'b0;
          R_READY   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Placed after the case so an abandon overrides whatever the bus state
      // branch scheduled this cycle.
      if (in_bus) begin
        if (tmo_hit && !bus_finishing) begin
          AW_VALID    <= 1'b0;
          W_VALID     <= 1'b0;
          AR_VALID    <= 1'b0;
          B_READY     <= 1'b0;
          R_READY     <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_write   <= cmd_write_q;
          rsp_rdata   <= '0;
          rsp_resp    <= 2'b10;
          rsp_timeout <= 1'b1;
          state       <= RSP;
          tcnt        <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// ---------------------------------------------------------------------------
// tb_axil_master
//   Bench for axil_master. A small AXI-Lite slave with a 16-word memory and
//   per-transaction ready/response delays sits on the bus. The reference model
//   is a word array updated at command issue time: every command pushes its
//   expected {rsp_write, rsp_rdata, rsp_resp, rsp_timeout} onto exp_q, and a
//   single negedge monitor checks responses and handshake rules every cycle.
// ---------------------------------------------------------------------------
module tb_axil_master;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TCYC = 16;
  localparam int EW   = 36;

  logic          ACLK;
  logic          ARESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic          AW_VALID;
  logic          AW_READY = 1'b0;
  logic [AW-1:0] AW_ADDR;
  logic          W_VALID;
  logic          W_READY = 1'b0;
  logic [DW-1:0] W_DATA;
  logic [3:0]    W_STRB;
  logic          B_VALID = 1'b0;
  logic          B_READY;
  logic [1:0]    B_RESP = 2'b00;
  logic          AR_VALID;
  logic          AR_READY = 1'b0;
  logic [AW-1:0] AR_ADDR;
  logic          R_VALID = 1'b0;
  logic          R_READY;
  logic [DW-1:0] R_DATA = '0;
  logic [1:0]    R_RESP = 2'b00;
  logic [2:0]    dbg_state;

  axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TCYC)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0]   mdl_mem [16];
  logic [31:0]   slv_mem [16];
  logic [EW-1:0] exp_q [$];

  // per-transaction slave behaviour: nx_* staged by the driver, cur_* live
  int         nx_aw_dly, nx_w_dly, nx_ar_dly, nx_b_dly, nx_r_dly, nx_hold;
  logic [1:0] nx_resp;
  int         cur_aw_dly, cur_w_dly, cur_ar_dly, cur_b_dly, cur_r_dly, cur_hold;
  logic [1:0] cur_resp;
  bit         spur_on = 1'b0;

  // ---------------- slave + response sink ----------------
  int          aw_c, w_c, ar_c, b_c, r_c, rs_c;
  bit          aw_got, w_got, b_pend, r_pend, mem_loaded;
  logic [31:0] wa, wd, ra;
  logic [3:0]  ws;

  always @(posedge ACLK) begin
    if (ARESET) begin
      if (!mem_loaded) begin
        for (int i = 0; i < 16; i++) slv_mem[i] = mdl_mem[i];
        mem_loaded = 1'b1;
      end
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0; rs_c = 0;
      cur_aw_dly = 0; cur_w_dly = 0; cur_ar_dly = 0; cur_b_dly = 0;
      cur_r_dly = 0; cur_hold = 0; cur_resp = 2'b00;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cur_aw_dly = nx_aw_dly; cur_w_dly = nx_w_dly; cur_ar_dly = nx_ar_dly;
        cur_b_dly = nx_b_dly; cur_r_dly = nx_r_dly; cur_hold = nx_hold;
        cur_resp = nx_resp;
      end
      if (AW_VALID && AW_READY) begin wa = AW_ADDR; aw_got = 1; aw_c = 0; end
      else if (AW_VALID) aw_c++;
      if (W_VALID && W_READY) begin wd = W_DATA; ws = W_STRB; w_got = 1; w_c = 0; end
      else if (W_VALID) w_c++;
      if (b_pend) begin
        if (B_VALID && B_READY) b_pend = 0;
        else b_c++;
      end else if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) slv_mem[wa[5:2]][8*b +: 8] = wd[8*b +: 8];
        b_pend = 1; b_c = 0; aw_got = 0; w_got = 0;
      end
      if (AR_VALID && AR_READY) ar_c = 0;
      else if (AR_VALID) ar_c++;
      if (r_pend) begin
        if (R_VALID && R_READY) r_pend = 0;
        else r_c++;
      end else if (AR_VALID && AR_READY) begin
        ra = AR_ADDR; r_pend = 1; r_c = 0;
      end
      if (rsp_valid && rsp_ready) rs_c = 0;
      else if (rsp_valid) rs_c++;
    end
    #1;
    AW_READY  = (aw_c >= cur_aw_dly);
    W_READY   = (w_c  >= cur_w_dly);
    AR_READY  = (ar_c >= cur_ar_dly);
    B_VALID   = b_pend ? (b_c >= cur_b_dly) : (spur_on ? 1'($urandom_range(0, 1)) : 1'b0);
    B_RESP    = b_pend ? cur_resp : 2'($urandom_range(0, 3));
    R_VALID   = r_pend ? (r_c >= cur_r_dly) : (spur_on ? 1'($urandom_range(0, 1)) : 1'b0);
    R_RESP    = r_pend ? cur_resp : 2'($urandom_range(0, 3));
    R_DATA    = r_pend ? slv_mem[ra[5:2]] : $urandom;
    rsp_ready = (rs_c >= cur_hold);
  end

  // ---------------- compare process ----------------
  logic          p_rst = 1'b1;
  logic          p_aw_valid, p_aw_ready, p_w_valid, p_w_ready, p_ar_valid, p_ar_ready;
  logic          p_rsp_valid, p_rsp_ready;
  logic [31:0]   p_aw_addr, p_ar_addr, p_w_data;
  logic [3:0]    p_w_strb;
  logic [EW-1:0] p_rsp;
  logic [EW-1:0] last_rsp = '0;
  int            n_rsp = 0;
  int            lat = 0, aw_hi = 0, w_hi = 0, rv_hi = 0;
  bit            lat_run = 0;

  always @(negedge ACLK) begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    got = {rsp_write, rsp_rdata, rsp_resp, rsp_timeout};
    if (!ARESET) begin
      if (AW_VALID) aw_hi++;
      if (W_VALID)  w_hi++;
      if (rsp_valid) rv_hi++;
      if (lat_run) begin
        if (rsp_valid) lat_run = 0;
        else lat++;
      end
      if (cmd_valid && cmd_ready) begin
        lat = 0; aw_hi = 0; w_hi = 0; rv_hi = 0; lat_run = 1;
      end
      if (rsp_valid) begin
        check("rsp_cmd_ready_low", cmd_ready, 1'b0);
        check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("rsp_payload", got, exp);
        last_rsp = got;
        n_rsp++;
      end
      if (B_READY) check("b_ready_phase", 64'(b_pend), 64'd1);
      if (R_READY) check("r_ready_phase", 64'(r_pend), 64'd1);
      if (!p_rst) begin
        if (p_aw_valid && !p_aw_ready)
          check("aw_hold", {AW_VALID, AW_ADDR}, {1'b1, p_aw_addr});
        if (p_w_valid && !p_w_ready)
          check("w_hold", {W_VALID, W_DATA, W_STRB}, {1'b1, p_w_data, p_w_strb});
        if (p_ar_valid && !p_ar_ready)
          check("ar_hold", {AR_VALID, AR_ADDR}, {1'b1, p_ar_addr});
        if (p_rsp_valid && !p_rsp_ready)
          check("rsp_hold", {rsp_valid, got}, {1'b1, p_rsp});
        if (p_rsp_valid && p_rsp_ready)
          check("cmd_ready_after_rsp", cmd_ready, 1'b1);
      end
    end
    p_rst = ARESET;
    p_aw_valid = AW_VALID; p_aw_ready = AW_READY; p_aw_addr = AW_ADDR;
    p_w_valid = W_VALID; p_w_ready = W_READY; p_w_data = W_DATA; p_w_strb = W_STRB;
    p_ar_valid = AR_VALID; p_ar_ready = AR_READY; p_ar_addr = AR_ADDR;
    p_rsp_valid = rsp_valid; p_rsp_ready = rsp_ready; p_rsp = got;
  end

  // ---------------- driver tasks (called 1 time unit after a rising edge) ----------------
  task automatic issue(input bit wr, input int idx, input logic [31:0] data,
                       input logic [3:0] strb, input logic [1:0] resp,
                       input int awd, input int wdl, input int ard, input int bd,
                       input int rd, input int hold, input bit tmo);
    int k;
    nx_aw_dly = awd; nx_w_dly = wdl; nx_ar_dly = ard; nx_b_dly = bd;
    nx_r_dly = rd; nx_hold = hold; nx_resp = resp;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
      exp_q.push_back({1'b1, 32'h0, resp, 1'b0});
    end else begin
      exp_q.push_back({1'b0, mdl_mem[idx], resp, 1'b0});
    end
    if (tmo) begin
      void'(exp_q.pop_back());
      exp_q.push_back({wr, 32'h0, 2'b10, 1'b1});
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = 32'(idx * 4);
    cmd_wdata = data; cmd_wstrb = strb;
    k = 0;
    forever begin
      @(posedge ACLK);
      if (cmd_ready) break;
      k++;
      if (k >= 200) begin
        n_checks++; n_errors++;
        $display("FAIL cmd_accept: cmd_ready not seen within %0d cycles", k);
        break;
      end
    end
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom_range(0, 1));
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge ACLK);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles", exp_q.size(), k);
      exp_q.delete();
    end
    @(posedge ACLK); #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {cmd_ready, AW_VALID, W_VALID, AR_VALID, B_READY, R_READY,
                 rsp_valid, rsp_write, rsp_resp, rsp_timeout, rsp_rdata}, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          wr;
    int          idx, k, n0;
    logic [31:0] data;

    for (int i = 0; i < 16; i++) mdl_mem[i] = $urandom;
    mdl_mem[2] = 32'h12DEAD34;

    // reset
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check_idle_outputs("reset_outputs");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);

    // write 0x8 = 0xDEADBEEF, strb 0xC, slave always ready, OKAY
    issue(1, 2, 32'hDEADBEEF, 4'hC, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    wait_done();
    check("wr_rsp_literal", last_rsp, {1'b1, 32'h0, 2'b00, 1'b0});
    check("wr_aw_one_cycle", aw_hi, 1);
    check("wr_w_one_cycle", w_hi, 1);
    check("wr_latency", lat, 2);

    // read back 0x8: 0x12DEAD34 merged with upper half of 0xDEADBEEF
    issue(0, 2, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    wait_done();
    check("rd_rsp_literal", last_rsp, {1'b0, 32'hDEADAD34, 2'b00, 1'b0});

    // AW_READY held off 3 cycles, W immediate
    n0 = n_rsp;
    issue(1, 5, 32'hCAFE0130, 4'hF, 2'b00, 3, 0, 0, 0, 0, 0, 0);
    wait_done();
    check("aw_delay_aw_cycles", aw_hi, 4);
    check("aw_delay_w_cycles", w_hi, 1);
    check("aw_delay_single_rsp", n_rsp - n0, 1);

    // read with rsp_ready low for 5 cycles
    issue(0, 5, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 5, 0);
    wait_done();
    check("rsp_hold_cycles", rv_hi, 6);
    check("rsp_hold_literal", last_rsp, {1'b0, 32'hCAFE0130, 2'b00, 1'b0});

    // reset while waiting for B
    issue(1, 7, 32'h0BADF00D, 4'hF, 2'b00, 0, 0, 0, 50, 0, 0, 0);
    k = 0;
    while (!B_READY && k < 60) begin
      @(posedge ACLK); #1;
      k++;
    end
    check("reached_wr_resp", B_READY, 1'b1);
    ARESET = 1'b1;
    exp_q.delete();
    @(posedge ACLK); #1;
    check_idle_outputs("mid_reset_outputs");
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("cmd_ready_after_mid_reset", cmd_ready, 1'b1);
    issue(0, 7, 32'h0, 4'h0, 2'b01, 1, 1, 2, 1, 2, 1, 0);
    wait_done();
    check("rd_after_reset_literal", last_rsp, {1'b0, 32'h0BADF00D, 2'b01, 1'b0});

    // randomized traffic, back-to-back and gapped, spurious B/R outside their phase
    spur_on = 1'b1;
    for (int t = 0; t < 300; t++) begin
      wr   = 1'($urandom_range(0, 1));
      idx  = $urandom_range(0, 15);
      data = $urandom;
      issue(wr, idx, data, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
      if ($urandom_range(0, 3) == 0) wait_done();
      else repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
    end
    wait_done();
    spur_on = 1'b0;

`ifdef AXIL_MASTER_TIMEOUT_EN
    // B never arrives: abandoned after TCYC cycles in bus states
    issue(1, 3, 32'h13572468, 4'hF, 2'b00, 0, 0, 0, 100000, 0, 0, 1);
    wait_done();
    check("timeout_latency", lat, TCYC);
    check("timeout_literal", last_rsp, {1'b1, 32'h0, 2'b10, 1'b1});
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
